// File: rtl/adc_read_arbiter.sv
// adc_read_arbiter
// Round-robin arbiter and read sequencer that shares one Avalon-MM ADC slave
// between NREQ requesters. It grants one requester per transaction, issues the
// read, and returns the sample to that requester with a one-cycle valid pulse.
//
// Optional feature macro: ADC_TIMEOUT_EN
//   defined   : a cycle counter bounds the RD state. On expiry the requester
//               gets rsp_valid with rsp_err = 1 and rsp_data = 0.
//   undefined : RD waits indefinitely for the slave and rsp_err is tied 0.

module adc_read_arbiter #(
  parameter int NREQ        = 2,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_addr,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              avm_read,
  output logic              avm_write,
  output logic              avm_address,
  output logic              avm_burstcount,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam int IDX_W = $clog2(NREQ);

  // Reject configurations the pointer and grant logic are not built for.
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("adc_read_arbiter: NREQ must be in 2..8");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("adc_read_arbiter: TIMEOUT_CYC must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    REL  = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] last;   // requester served by the previous transaction
  logic [IDX_W-1:0] cur;    // requester owning the current transaction
  logic [IDX_W-1:0] pick;   // round-robin winner among the live requests
  logic [IDX_W-1:0] cand;
  logic             found;

`ifdef ADC_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] rd_cnt;
`endif

  // The slave only ever sees single-beat reads.
  assign avm_write      = 1'b0;
  assign avm_burstcount = 1'b1;

  // Round-robin winner: first set request scanning upward from last+1, wrapping.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no
    // path through the block can leave one unassigned and infer a latch.
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(last) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Transaction sequencer: IDLE -> RD -> REL -> IDLE, all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: state uses non-blocking assignments so every register updates
      // from values sampled at the same edge, independent of statement order.
      state       <= IDLE;
      last        <= IDX_W'(NREQ - 1);  // requester 0 wins the first arbitration
      cur         <= '0;
      gnt         <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      busy        <= 1'b0;
`ifdef ADC_TIMEOUT_EN
      rsp_err     <= 1'b0;
      rd_cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // A stray readdatavalid here is deliberately ignored.
          if (found) begin
            cur         <= pick;
            gnt         <= NREQ'(1) << pick;
            avm_address <= req_addr[pick];
            avm_read    <= 1'b1;
            busy        <= 1'b1;
            state       <= RD;
`ifdef ADC_TIMEOUT_EN
            rd_cnt      <= '0;
`endif
          end
        end

        RD: begin
          // Valid data takes precedence over a timeout on the same edge.
          if (avm_readdatavalid) begin
            avm_read  <= 1'b0;
            rsp_data  <= avm_readdata;
            rsp_valid <= gnt;
            state     <= REL;
`ifdef ADC_TIMEOUT_EN
            rsp_err   <= 1'b0;
          end else if (rd_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            avm_read  <= 1'b0;
            rsp_data  <= '0;
            rsp_valid <= gnt;
            rsp_err   <= 1'b1;
            state     <= REL;
          end else begin
            rd_cnt    <= rd_cnt + CNT_W'(1);
`endif
          end
        end

        REL: begin
          // Response pulse lasts exactly one cycle; grant holds until the
          // slave drops readdatavalid so a long valid cannot start a new read.
          rsp_valid <= '0;
`ifdef ADC_TIMEOUT_EN
          rsp_err   <= 1'b0;
`endif
          if (!avm_readdatavalid) begin
            gnt   <= '0;
            last  <= cur;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef ADC_TIMEOUT_EN
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_read_arbiter.sv
// tb_adc_read_arbiter
// Self-checking bench for adc_read_arbiter (NREQ = 2). A behavioural Avalon
// slave answers reads after a programmable delay with data derived from the
// address and a running transaction number; expected responses are queued
// when requests are driven and compared when rsp_valid pulses.
// Define ADC_TIMEOUT_EN for both files to include the timeout scenario.

module tb_adc_read_arbiter;

  localparam int NREQ        = 2;
  localparam int DATA_W      = 16;
  localparam int TIMEOUT_CYC = 16;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_addr;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              busy;
  logic              avm_read;
  logic              avm_write;
  logic              avm_address;
  logic              avm_burstcount;
  logic [DATA_W-1:0] rdata;
  logic              rdv;

  typedef struct {
    int                idx;
    logic [DATA_W-1:0] data;
    logic              err;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;
  int   txn_cnt;
  int   exp_last;

  // Slave configuration, written only by the main process.
  int slave_delay;
  bit slave_mute;
  int stray_cnt;

  // Slave state, written only by the slave process.
  int wait_cnt;
  int serve_cnt;
  int stray_done;

  adc_read_arbiter #(
    .NREQ        (NREQ),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk               (clk),
    .reset             (rst_n),
    .req               (req),
    .req_addr          (req_addr),
    .gnt               (gnt),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .rsp_err           (rsp_err),
    .busy              (busy),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_address       (avm_address),
    .avm_burstcount    (avm_burstcount),
    .avm_readdata      (rdata),
    .avm_readdatavalid (rdv)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DATA_W-1:0] model_data(input logic addr, input int n);
    return 16'h0A5C + 16'(n * 'h0111) + (addr ? 16'h4000 : 16'h0000);
  endfunction

  function automatic int next_winner(input logic [NREQ-1:0] r, input int prev);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(prev + k) % NREQ]) return (prev + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic push_txn(input int idx, input logic addr);
    exp_t e;
    e.idx  = idx;
    e.data = model_data(addr, txn_cnt);
    e.err  = 1'b0;
    exp_q.push_back(e);
    txn_cnt++;
  endtask

  // Behavioural slave: one-cycle readdatavalid after slave_delay read cycles.
  initial begin
    rdv = 1'b0; rdata = '0; wait_cnt = 0; serve_cnt = 0; stray_done = 0;
    forever begin
      @(posedge clk); #2;
      if (rdv) begin
        rdv   = 1'b0;
        rdata = '0;
      end else if (avm_read === 1'b1) begin
        if (!slave_mute && wait_cnt >= slave_delay) begin
          rdv      = 1'b1;
          rdata    = model_data(avm_address, serve_cnt);
          serve_cnt++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        if (stray_cnt != stray_done) begin
          stray_done++;
          rdv   = 1'b1;
          rdata = 16'hDEAD;
        end
      end
    end
  end

  task automatic wait_rsp(input int max_cyc, output bit seen, output int cyc);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < max_cyc) begin
      @(posedge clk); #1;
      cyc++;
      if (rsp_valid !== '0) seen = 1'b1;
    end
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    int c = 0;
    ok = 1'b0;
    while (!ok && c < max_cyc) begin
      @(posedge clk); #1;
      c++;
      if (busy === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; req = '0; req_addr = '0;
    slave_delay = 0; slave_mute = 1'b0; stray_cnt = 0; txn_cnt = 0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (gnt !== '0) begin bad++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    total++; if (rsp_valid !== '0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    total++; if (rsp_data !== '0) begin bad++; $display("FAIL reset_rsp_data: got %h want 0000", rsp_data); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (avm_read !== 1'b0) begin bad++; $display("FAIL reset_avm_read: got %b want 0", avm_read); end
    total++; if (avm_address !== 1'b0) begin bad++; $display("FAIL reset_avm_address: got %b want 0", avm_address); end
    total++; if (avm_write !== 1'b0) begin bad++; $display("FAIL reset_avm_write: got %b want 0", avm_write); end
    total++; if (avm_burstcount !== 1'b1) begin bad++; $display("FAIL reset_burstcount: got %b want 1", avm_burstcount); end
    rst_n = 1'b1;
    exp_last = NREQ - 1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0 || avm_read !== 1'b0 || gnt !== '0) begin
      bad++; $display("FAIL idle_no_req: got busy=%b read=%b gnt=%b want 0 0 00", busy, avm_read, gnt);
    end
  endtask

  task automatic test_single();
    exp_t e; bit seen; bit ok; int cyc;
    logic [NREQ-1:0] want;
    slave_delay = 50; req_addr = 2'b00;
    push_txn(next_winner(2'b01, exp_last), 1'b0);
    req = 2'b01;
    total++; if (avm_read !== 1'b0) begin bad++; $display("FAIL single_read_early: got %b want 0", avm_read); end
    @(posedge clk); #1;
    total++; if (avm_read !== 1'b1) begin bad++; $display("FAIL single_read_latency: got %b want 1", avm_read); end
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL single_gnt: got %b want 01", gnt); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
    wait_rsp(200, seen, cyc);
    req = '0;
    e = exp_q.pop_front();
    want = NREQ'(1) << e.idx;
    total++; if (!seen || cyc != 51) begin bad++; $display("FAIL single_rsp_time: got seen=%b cycles=%0d want seen=1 cycles=51", seen, cyc); end
    total++; if (rsp_valid !== want) begin bad++; $display("FAIL single_rsp_valid: got %b want %b", rsp_valid, want); end
    total++; if (rsp_data !== e.data) begin bad++; $display("FAIL single_rsp_data: got %h want %h", rsp_data, e.data); end
    total++; if (rsp_err !== e.err) begin bad++; $display("FAIL single_rsp_err: got %b want %b", rsp_err, e.err); end
    exp_last = e.idx;
    @(posedge clk); #1;
    total++; if (rsp_valid !== '0) begin bad++; $display("FAIL single_pulse_width: got %b want 00", rsp_valid); end
    wait_idle(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_release: got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    exp_t e; bit seen; bit ok; int cyc; int l; int w;
    logic [NREQ-1:0] want;
    slave_delay = 0; req_addr = 2'b10;
    l = exp_last;
    for (int i = 0; i < 4; i++) begin
      w = next_winner(2'b11, l);
      push_txn(w, req_addr[w]);
      l = w;
    end
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_rsp(50, seen, cyc);
      if (i == 3) req = '0;
      e = exp_q.pop_front();
      want = NREQ'(1) << e.idx;
      total++; if (!seen || rsp_valid !== want) begin bad++; $display("FAIL rr_valid[%0d]: got %b want %b", i, rsp_valid, want); end
      total++; if (gnt !== want) begin bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt, want); end
      total++; if (rsp_data !== e.data) begin bad++; $display("FAIL rr_data[%0d]: got %h want %h", i, rsp_data, e.data); end
      total++; if (rsp_err !== e.err) begin bad++; $display("FAIL rr_err[%0d]: got %b want %b", i, rsp_err, e.err); end
      exp_last = e.idx;
      @(posedge clk); #1;
      total++; if (rsp_valid !== '0 || busy !== 1'b0) begin
        bad++; $display("FAIL rr_gap[%0d]: got valid=%b busy=%b want 00 0", i, rsp_valid, busy);
      end
      if (i < 3) begin
        @(posedge clk); #1;
        want = NREQ'(1) << exp_q[0].idx;
        total++; if (busy !== 1'b1 || gnt !== want) begin
          bad++; $display("FAIL rr_regrant[%0d]: got busy=%b gnt=%b want 1 %b", i, busy, gnt, want);
        end
      end
    end
    wait_idle(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL rr_release: got busy=%b want 0", busy); end
  endtask

  task automatic test_drop();
    exp_t e; bit seen; bit ok; int cyc; int w;
    logic [NREQ-1:0] want;
    slave_delay = 10; req_addr = 2'b10;
    push_txn(next_winner(2'b10, exp_last), 1'b1);
    req = 2'b10;
    @(posedge clk); #1;
    total++; if (gnt !== 2'b10) begin bad++; $display("FAIL drop_gnt: got %b want 10", gnt); end
    @(posedge clk); #1;
    req = '0;
    wait_rsp(50, seen, cyc);
    e = exp_q.pop_front();
    want = NREQ'(1) << e.idx;
    total++; if (!seen || rsp_valid !== want) begin bad++; $display("FAIL drop_valid: got %b want %b", rsp_valid, want); end
    total++; if (rsp_data !== e.data) begin bad++; $display("FAIL drop_data: got %h want %h", rsp_data, e.data); end
    exp_last = e.idx;
    wait_idle(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL drop_release: got busy=%b want 0", busy); end
    w = next_winner(2'b11, exp_last);
    push_txn(w, req_addr[w]);
    req = 2'b11;
    wait_rsp(50, seen, cyc);
    req = '0;
    e = exp_q.pop_front();
    want = NREQ'(1) << e.idx;
    total++; if (!seen || gnt !== want || rsp_valid !== want) begin
      bad++; $display("FAIL drop_next_grant: got gnt=%b valid=%b want %b", gnt, rsp_valid, want);
    end
    total++; if (rsp_data !== e.data) begin bad++; $display("FAIL drop_next_data: got %h want %h", rsp_data, e.data); end
    exp_last = e.idx;
    wait_idle(20, ok);
  endtask

  task automatic test_stray_valid();
    logic [DATA_W-1:0] held;
    held = rsp_data;
    stray_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++; if (rsp_valid !== '0 || busy !== 1'b0) begin
        bad++; $display("FAIL stray_idle[%0d]: got valid=%b busy=%b want 00 0", i, rsp_valid, busy);
      end
    end
    total++; if (rsp_data !== held) begin bad++; $display("FAIL stray_data: got %h want %h", rsp_data, held); end
  endtask

  task automatic test_reset_mid();
    exp_t e; bit seen; bit ok; int cyc; int w;
    logic [NREQ-1:0] want;
    slave_delay = 1000; req_addr = 2'b00;
    req = 2'b10;
    @(posedge clk); #1;
    total++; if (avm_read !== 1'b1 || gnt !== 2'b10) begin
      bad++; $display("FAIL rstmid_start: got read=%b gnt=%b want 1 10", avm_read, gnt);
    end
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++; if (avm_read !== 1'b0 || gnt !== '0 || busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_async: got read=%b gnt=%b busy=%b want 0 00 0", avm_read, gnt, busy);
    end
    req = '0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++; if (rsp_valid !== '0) begin bad++; $display("FAIL rstmid_no_pulse[%0d]: got %b want 00", i, rsp_valid); end
    end
    rst_n = 1'b1;
    exp_last = NREQ - 1;
    slave_delay = 1;
    w = next_winner(2'b11, exp_last);
    push_txn(w, req_addr[w]);
    req = 2'b11;
    wait_rsp(50, seen, cyc);
    req = '0;
    e = exp_q.pop_front();
    want = NREQ'(1) << e.idx;
    total++; if (!seen || gnt !== want || rsp_valid !== want) begin
      bad++; $display("FAIL rstmid_first_grant: got gnt=%b valid=%b want %b", gnt, rsp_valid, want);
    end
    total++; if (rsp_data !== e.data) begin bad++; $display("FAIL rstmid_data: got %h want %h", rsp_data, e.data); end
    exp_last = e.idx;
    wait_idle(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_release: got busy=%b want 0", busy); end
  endtask

`ifdef ADC_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e; bit ok; int cnt;
    logic [NREQ-1:0] want;
    slave_mute = 1'b1;
    e.idx = next_winner(2'b01, exp_last); e.data = '0; e.err = 1'b1;
    exp_q.push_back(e);
    req = 2'b01;
    @(posedge clk); #1;
    cnt = 0;
    while (avm_read === 1'b1 && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    req = '0;
    e = exp_q.pop_front();
    want = NREQ'(1) << e.idx;
    total++; if (cnt != TIMEOUT_CYC) begin bad++; $display("FAIL timeout_rd_cycles: got %0d want %0d", cnt, TIMEOUT_CYC); end
    total++; if (rsp_valid !== want) begin bad++; $display("FAIL timeout_valid: got %b want %b", rsp_valid, want); end
    total++; if (rsp_err !== e.err) begin bad++; $display("FAIL timeout_err: got %b want %b", rsp_err, e.err); end
    total++; if (rsp_data !== e.data) begin bad++; $display("FAIL timeout_data: got %h want %h", rsp_data, e.data); end
    exp_last = e.idx;
    slave_mute = 1'b0;
    wait_idle(20, ok);
    total++; if (!ok || rsp_err !== 1'b0) begin bad++; $display("FAIL timeout_release: got busy=%b err=%b want 0 0", busy, rsp_err); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_drop();
    test_stray_valid();
    test_reset_mid();
`ifdef ADC_TIMEOUT_EN
    test_timeout();
`endif
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
